// File: rtl/img_pkg.sv
// Shared image-pipeline definitions.
// Holds the frame-sequencer state type, the default frame geometry and sync
// delays used by the image source, the reader and the writer, and a small
// width helper for counters whose range may collapse to a single value.
package img_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_HSYNC = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } frame_state_t;

  localparam int IMG_WIDTH          = 1920;
  localparam int IMG_HEIGHT         = 1080;
  localparam int IMG_START_UP_DELAY = 100;
  localparam int IMG_HSYNC_DELAY    = 160;
  localparam int IMG_ADDR_W         = 21;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order pixel counters.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   clear        : return all counters to pixel 0 on the next edge
//   advance      : step one pixel in raster order on the next edge
//   col, row     : current column / row index
//   rd_addr      : linear pixel address, kept equal to row*WIDTH+col
//   last_col     : current column is the last one of the row
//   last_pix     : current pixel is the last one of the frame
module raster_addr_gen
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = IMG_ADDR_W,
  localparam int COL_W = clog2_min1(WIDTH),
  localparam int ROW_W = clog2_min1(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last_col,
  output logic              last_pix
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_col = (col_q == COL_W'(WIDTH - 1));
  assign last_pix = last_col && (row_q == ROW_W'(HEIGHT - 1));

  // The address walks alongside col/row with a plain incrementer: raster
  // order makes row*WIDTH+col advance by exactly one per accepted pixel.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col     = col_q;
  assign row     = row_q;
  assign rd_addr = addr_q;

endmodule

// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: on a start request it runs one VSYNC window, then for
// every row an HSYNC blanking window followed by raster-order memory reads
// that stall whenever the consumer is not ready.
// Ports:
//   HCLK, HRESET : clock and synchronous active-high reset
//   start        : frame request, only looked at while idle
//   abort        : drop the current frame and return to idle at once
//   out_ready    : consumer can take a pixel this cycle
//   busy         : any state other than idle
//   VSYNC, HSYNC : frame start-up window / per-row blanking window
//   rd_en        : memory read strobe for rd_addr this cycle
//   rd_addr      : linear pixel address (row*WIDTH+col)
//   row, col     : current raster position
//   pix_valid    : rd_en one cycle later, lines up with memory read data
//   ctrl_done    : single-cycle pulse when a frame completes normally
module frame_read_sequencer
  import img_pkg::*;
#(
  parameter int WIDTH          = IMG_WIDTH,
  parameter int HEIGHT         = IMG_HEIGHT,
  parameter int START_UP_DELAY = IMG_START_UP_DELAY,
  parameter int HSYNC_DELAY    = IMG_HSYNC_DELAY,
  parameter int ADDR_W         = IMG_ADDR_W,
  localparam int ROW_W = clog2_min1(HEIGHT),
  localparam int COL_W = clog2_min1(WIDTH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              pix_valid,
  output logic              ctrl_done
);

  localparam int MAX_DELAY = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(START_UP_DELAY - 1);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(HSYNC_DELAY - 1);

  frame_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pix_valid_q, pix_valid_d;
  logic             cancel, advance, clear;
  logic             last_col, last_pix;

  // abort only matters once a frame is under way; while idle a start wins.
  assign cancel = abort && (state_q != S_IDLE);
  assign rd_en  = (state_q == S_DATA) && out_ready && !abort;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_VSYNC;
      S_VSYNC: if (cnt_q == VS_LAST) state_d = S_HSYNC;
      S_HSYNC: if (cnt_q == HS_LAST) state_d = S_DATA;
      S_DATA: begin
        if (out_ready) begin
          // The final pixel leaves the counters parked on it through DONE;
          // they are cleared when DONE hands back to IDLE.
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            if (last_col) state_d = S_HSYNC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    if (cancel) begin
      state_d = S_IDLE;
      advance = 1'b0;
      clear   = 1'b1;
    end

    // One delay counter serves both sync windows; it restarts from zero on
    // every state change and idles at zero outside the timed states.
    if ((state_d != state_q) || !((state_q == S_VSYNC) || (state_q == S_HSYNC))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pix_valid_d = rd_en;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  raster_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk      (HCLK),
    .rst      (HRESET),
    .clear    (clear),
    .advance  (advance),
    .col      (col),
    .row      (row),
    .rd_addr  (rd_addr),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  assign busy      = (state_q != S_IDLE);
  assign VSYNC     = (state_q == S_VSYNC);
  assign HSYNC     = (state_q == S_HSYNC);
  assign ctrl_done = (state_q == S_DONE) && !abort;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_frame_read_sequencer.sv
module tb_frame_read_sequencer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int SUD = 3;
  localparam int HD  = 2;
  localparam int AW  = 3;

  localparam int P_IDLE = 0;
  localparam int P_VS   = 1;
  localparam int P_HS   = 2;
  localparam int P_DATA = 3;
  localparam int P_DONE = 4;

  logic          HCLK = 1'b0;
  logic          HRESET, start, abort, out_ready;
  logic          busy, VSYNC, HSYNC, rd_en, pix_valid, ctrl_done;
  logic [AW-1:0] rd_addr;
  logic [0:0]    row;
  logic [1:0]    col;

  frame_read_sequencer #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .START_UP_DELAY (SUD),
    .HSYNC_DELAY    (HD),
    .ADDR_W         (AW)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .row       (row),
    .col       (col),
    .pix_valid (pix_valid),
    .ctrl_done (ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, cycles left in the sync window, raster
  // position. Address is derived arithmetically from the position.
  int   m_ph  = P_IDLE;
  int   m_rem = 0;
  int   m_r   = 0;
  int   m_c   = 0;
  logic m_pv  = 1'b0;
  logic e_rd_en;

  assign e_rd_en = (m_ph == P_DATA) && out_ready && !abort;

  always @(posedge HCLK) begin : model
    int ph, rem, r, c;
    ph = m_ph; rem = m_rem; r = m_r; c = m_c;
    if (HRESET) begin
      ph = P_IDLE; rem = 0; r = 0; c = 0;
    end else if (ph != P_IDLE && abort) begin
      ph = P_IDLE; rem = 0; r = 0; c = 0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin ph = P_VS; rem = SUD; end
        P_VS: begin
          rem = rem - 1;
          if (rem == 0) begin ph = P_HS; rem = HD; end
        end
        P_HS: begin
          rem = rem - 1;
          if (rem == 0) ph = P_DATA;
        end
        P_DATA: begin
          if (out_ready) begin
            if (c == W - 1) begin
              if (r == H - 1) ph = P_DONE;
              else begin r = r + 1; c = 0; ph = P_HS; rem = HD; end
            end else begin
              c = c + 1;
            end
          end
        end
        default: begin ph = P_IDLE; r = 0; c = 0; end
      endcase
    end
    m_pv  <= HRESET ? 1'b0 : e_rd_en;
    m_ph  <= ph;
    m_rem <= rem;
    m_r   <= r;
    m_c   <= c;
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("busy",      32'(busy),      32'(m_ph != P_IDLE));
      chk("VSYNC",     32'(VSYNC),     32'(m_ph == P_VS));
      chk("HSYNC",     32'(HSYNC),     32'(m_ph == P_HS));
      chk("rd_en",     32'(rd_en),     32'(e_rd_en));
      chk("rd_addr",   32'(rd_addr),   32'(m_r * W + m_c));
      chk("row",       32'(row),       32'(m_r));
      chk("col",       32'(col),       32'(m_c));
      chk("pix_valid", 32'(pix_valid), 32'(m_pv));
      chk("ctrl_done", 32'(ctrl_done), 32'((m_ph == P_DONE) && !abort));
    end
  end

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  // Hand-derived timeline of an unstalled 4x2 frame, cycle c after the
  // cycle in which start is presented.
  task automatic check_basic(input string tag, input int c);
    logic rde;
    rde = (c >= 6 && c <= 9) || (c >= 12 && c <= 15);
    chk({tag, "_VSYNC"},     32'(VSYNC),     32'(c >= 1 && c <= 3));
    chk({tag, "_HSYNC"},     32'(HSYNC),     32'((c >= 4 && c <= 5) || (c >= 10 && c <= 11)));
    chk({tag, "_rd_en"},     32'(rd_en),     32'(rde));
    if (rde) chk({tag, "_rd_addr"}, 32'(rd_addr), 32'((c <= 9) ? c - 6 : c - 8));
    chk({tag, "_ctrl_done"}, 32'(ctrl_done), 32'(c == 16));
    chk({tag, "_busy"},      32'(busy),      32'(c >= 1 && c <= 16));
    if (c == 12) chk({tag, "_model_row"},  32'(m_r),  32'(1));
    if (c == 16) chk({tag, "_model_done"}, 32'(m_ph), 32'(P_DONE));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int pv;
    int g;
    HRESET = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    smp();
    chk("reset_busy",      32'(busy),      32'(0));
    chk("reset_rd_addr",   32'(rd_addr),   32'(0));
    chk("reset_pix_valid", 32'(pix_valid), 32'(0));
    chk("reset_ctrl_done", 32'(ctrl_done), 32'(0));
    chk_en = 1'b1;
    nxt(); HRESET = 1'b0;
    smp();

    // Basic frame
    nxt(); start = 1'b1; out_ready = 1'b1; smp();
    pv = 0;
    for (int c = 1; c <= 17; c++) begin
      nxt(); start = 1'b0; smp();
      check_basic("basic", c);
      if (pix_valid) pv++;
    end
    chk("basic_pix_valid_count", 32'(pv), 32'(8));

    // Back-pressure in cycles 7-8
    nxt(); start = 1'b1; smp();
    pv = 0;
    for (int c = 1; c <= 19; c++) begin
      nxt(); start = 1'b0; out_ready = !(c == 7 || c == 8); smp();
      if (c == 7 || c == 8) begin
        chk("bp_rd_en_stall", 32'(rd_en),   32'(0));
        chk("bp_addr_hold",   32'(rd_addr), 32'(1));
      end
      if (c == 9) begin
        chk("bp_rd_en_resume", 32'(rd_en),   32'(1));
        chk("bp_addr_resume",  32'(rd_addr), 32'(1));
      end
      if (c == 16) chk("bp_no_early_done", 32'(ctrl_done), 32'(0));
      if (c == 18) chk("bp_done",          32'(ctrl_done), 32'(1));
      if (c == 19) chk("bp_idle",          32'(busy),      32'(0));
      if (pix_valid) pv++;
    end
    chk("bp_pix_valid_count", 32'(pv), 32'(8));
    out_ready = 1'b1;

    // Abort in HSYNC at cycle 11, new start at cycle 13
    nxt(); start = 1'b1; smp();
    for (int c = 1; c <= 12; c++) begin
      nxt(); start = 1'b0; abort = (c == 11); smp();
      if (c <= 10) check_basic("abort_pre", c);
      if (c == 11) begin
        chk("abort_hsync", 32'(HSYNC),     32'(1));
        chk("abort_done",  32'(ctrl_done), 32'(0));
      end
      if (c == 12) begin
        chk("abort_idle", 32'(busy),      32'(0));
        chk("abort_addr", 32'(rd_addr),   32'(0));
        chk("abort_row",  32'(row),       32'(0));
        chk("abort_done2",32'(ctrl_done), 32'(0));
      end
    end
    nxt(); start = 1'b1; smp();
    for (int k = 1; k <= 17; k++) begin
      nxt(); start = 1'b0; smp();
      check_basic("abort_replay", k);
    end

    // Reset mid-DATA at cycle 8, restart straight after release
    nxt(); start = 1'b1; smp();
    for (int c = 1; c <= 9; c++) begin
      nxt(); start = (c == 9); HRESET = (c == 8); smp();
      if (c == 8) begin
        chk("rst_pre_rd_en", 32'(rd_en),   32'(1));
        chk("rst_pre_addr",  32'(rd_addr), 32'(2));
      end
      if (c == 9) begin
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_vsync",     32'(VSYNC),     32'(0));
        chk("rst_hsync",     32'(HSYNC),     32'(0));
        chk("rst_rd_en",     32'(rd_en),     32'(0));
        chk("rst_pix_valid", 32'(pix_valid), 32'(0));
        chk("rst_ctrl_done", 32'(ctrl_done), 32'(0));
        chk("rst_addr",      32'(rd_addr),   32'(0));
        chk("rst_row",       32'(row),       32'(0));
        chk("rst_col",       32'(col),       32'(0));
      end
    end
    for (int k = 1; k <= 17; k++) begin
      nxt(); start = 1'b0; smp();
      check_basic("rst_restart", k);
    end

    // start held high: ignored while busy, back-to-back frames
    nxt(); start = 1'b1; smp();
    for (int c = 1; c <= 21; c++) begin
      nxt(); start = 1'b1; smp();
      if (c <= 16) check_basic("b2b", c);
      if (c == 17) chk("b2b_idle_gap", 32'(busy), 32'(0));
      if (c >= 18 && c <= 20) chk("b2b_vsync2", 32'(VSYNC), 32'(1));
      if (c == 21) chk("b2b_hsync2", 32'(HSYNC), 32'(1));
    end
    start = 1'b0;
    g = 0;
    while (busy && g < 60) begin
      nxt(); smp();
      g++;
    end
    chk("b2b_drain", 32'(busy), 32'(0));

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      nxt();
      start     = ($urandom % 4) == 0;
      abort     = ($urandom % 40) == 0;
      out_ready = ($urandom % 4) != 0;
      HRESET    = ($urandom % 400) == 0;
      smp();
    end
    nxt();
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; HRESET = 1'b0;
    smp();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
